// File: rtl/bernoulli_sampler_if.sv
// Bundle of the signals between the sampler and its neighbours.
// - start is the sweep trigger.
// - The probability stream is prob_valid/prob_data/prob_ready.
// - rand_data is the random word.
// - The result stream is state_valid/state_data/ones_count/state_ready.
// - busy is a status flag.
// Handshake rule on both streams: a word transfers on a rising clk edge
// where valid and ready are both high. A producer holding valid keeps its
// data stable until that edge. Ready may depend on state, never on valid.
interface bernoulli_sampler_if #(
    parameter int bitlength = 8,
    parameter int NUM_UNITS = 16
);
    localparam int CNT_W = $clog2(NUM_UNITS + 1);

    logic                 start;
    logic                 prob_valid;
    logic [bitlength-1:0] prob_data;
    logic                 prob_ready;
    logic [bitlength-1:0] rand_data;
    logic                 state_valid;
    logic [NUM_UNITS-1:0] state_data;
    logic [CNT_W-1:0]     ones_count;
    logic                 state_ready;
    logic                 busy;

    // Environment side: produces probabilities and random words, consumes vectors.
    modport master (
        output start, prob_valid, prob_data, rand_data, state_ready,
        input  prob_ready, state_valid, state_data, ones_count, busy
    );

    // Sampler side.
    modport slave (
        input  start, prob_valid, prob_data, rand_data, state_ready,
        output prob_ready, state_valid, state_data, ones_count, busy
    );
endinterface

// File: rtl/bernoulli_sampler.sv
// Bernoulli sampler for the RBM Gibbs loop.
// - It collects NUM_UNITS probabilities per sweep.
// - Each unit fires when the current random word is below its probability.
// - The finished vector is presented together with its population count.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = SAMPLE, 2 = OUTPUT.
module bernoulli_sampler #(
    parameter int bitlength = 8,
    parameter int NUM_UNITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    bernoulli_sampler_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam int IDX_W = $clog2(NUM_UNITS);
    localparam int CNT_W = $clog2(NUM_UNITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_UNITS-1:0] state_data_q, state_data_d;
    logic [CNT_W-1:0]     ones_count_q, ones_count_d;
    logic                 state_valid_q, state_valid_d;
    logic                 fire;

    // Next-state, sweep bookkeeping and sample decision.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        state_data_d = state_data_q;
        ones_count_d = ones_count_q;
        fire         = (bus.rand_data < bus.prob_data);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = SAMPLE;
                    idx_d        = '0;
                    state_data_d = '0;
                    ones_count_d = '0;
                end
            end
            SAMPLE: begin
                // start is deliberately ignored here; only accepts advance the sweep.
                if (bus.prob_valid) begin
                    state_data_d[idx_q] = fire;
                    ones_count_d        = ones_count_q + CNT_W'(fire);
                    if (idx_q == IDX_W'(NUM_UNITS - 1)) begin
                        state_d = OUTPUT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            OUTPUT: begin
                // Vector held until consumed; a start in the same cycle chains a new sweep.
                if (bus.state_ready) begin
                    if (bus.start) begin
                        state_d      = SAMPLE;
                        idx_d        = '0;
                        state_data_d = '0;
                        ones_count_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        state_valid_d = (state_d == OUTPUT);
    end

    // State and result registers; reset drops any partial sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            state_data_q  <= '0;
            ones_count_q  <= '0;
            state_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            state_data_q  <= state_data_d;
            ones_count_q  <= ones_count_d;
            state_valid_q <= state_valid_d;
        end
    end

    assign bus.prob_ready  = (state_q == SAMPLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.state_valid = state_valid_q;
    assign bus.state_data  = state_data_q;
    assign bus.ones_count  = ones_count_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_bernoulli_sampler.sv
// Directed bench for bernoulli_sampler (bitlength=8, NUM_UNITS=16).
module tb_bernoulli_sampler;
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         tests_run;
    int         tests_failed;

    bernoulli_sampler_if #(.bitlength(8), .NUM_UNITS(16)) bus ();

    bernoulli_sampler #(.bitlength(8), .NUM_UNITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic accept(input logic [7:0] p, input logic [7:0] r);
        bus.prob_valid = 1'b1;
        bus.prob_data  = p;
        bus.rand_data  = r;
        tick();
        bus.prob_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.state_ready = 1'b1;
        tick();
        bus.state_ready = 1'b0;
    endtask

    // Full sweep from IDLE; checks latency and the final vector.
    task automatic run_sweep(input string tag, input logic [7:0] pv[16], input logic [7:0] rv[16],
                             input logic [15:0] exp_data, input logic [4:0] exp_cnt);
        start_sweep();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk({tag, "_valid_before_last"}, 32'(bus.state_valid), 32'd0);
            accept(pv[i], rv[i]);
        end
        chk({tag, "_valid"}, 32'(bus.state_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.state_data),  32'(exp_data));
        chk({tag, "_count"}, 32'(bus.ones_count),  32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] pv[16];
        logic [7:0] rv[16];
        logic [7:0] lfsr;
        int         total;

        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.prob_valid  = 1'b0;
        bus.prob_data   = '0;
        bus.rand_data   = '0;
        bus.state_ready = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_busy",   32'(bus.busy),        32'd0);
        chk("rst_valid",  32'(bus.state_valid), 32'd0);
        chk("rst_data",   32'(bus.state_data),  32'd0);
        chk("rst_count",  32'(bus.ones_count),  32'd0);
        chk("rst_pready", 32'(bus.prob_ready),  32'd0);
        chk("rst_fsm",    32'(state_dbg),       32'd0);
        reset = 1'b0;
        tick();
        chk("idle_fsm", 32'(state_dbg), 32'd0);

        // T1: reset after 5 accepts discards the partial vector.
        start_sweep();
        chk("t1_pready", 32'(bus.prob_ready), 32'd1);
        chk("t1_busy",   32'(bus.busy),       32'd1);
        for (int i = 0; i < 5; i++) accept(8'hFF, 8'h00);
        chk("t1_partial", 32'(bus.state_data), 32'h001F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t1_rst_busy",  32'(bus.busy),        32'd0);
        chk("t1_rst_valid", 32'(bus.state_valid), 32'd0);
        chk("t1_rst_data",  32'(bus.state_data),  32'd0);
        chk("t1_rst_count", 32'(bus.ones_count),  32'd0);
        // Clean sweep: even units p=FF, odd p=00, r=10 -> 0x5555, 8 ones.
        for (int i = 0; i < 16; i++) begin
            pv[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
            rv[i] = 8'h10;
        end
        run_sweep("t1_clean", pv, rv, 16'h5555, 5'd8);
        handshake();
        chk("t1_hs_valid", 32'(bus.state_valid), 32'd0);
        chk("t1_hs_busy",  32'(bus.busy),        32'd0);

        // T2: p=0 never fires; p=FF fires for any r below FF.
        for (int i = 0; i < 16; i++) begin
            pv[i] = 8'h00;
            rv[i] = 8'($urandom_range(0, 255));
        end
        run_sweep("t2_zero", pv, rv, 16'h0000, 5'd0);
        handshake();
        for (int i = 0; i < 16; i++) begin
            pv[i] = 8'hFF;
            rv[i] = 8'($urandom_range(0, 254));
        end
        run_sweep("t2_full", pv, rv, 16'hFFFF, 5'd16);
        chk("t2_pready_out", 32'(bus.prob_ready), 32'd0);
        chk("t2_fsm_out",    32'(state_dbg),      32'd2);
        handshake();

        // T3: compare edges; unit3 p=FF r=FF must not fire.
        for (int i = 0; i < 16; i++) begin
            pv[i] = 8'h00;
            rv[i] = 8'($urandom_range(0, 255));
        end
        pv[0] = 8'h80; rv[0] = 8'h7F;
        pv[1] = 8'h80; rv[1] = 8'h80;
        pv[2] = 8'h01; rv[2] = 8'h00;
        pv[3] = 8'hFF; rv[3] = 8'hFF;
        run_sweep("t3_edge", pv, rv, 16'h0005, 5'd2);
        handshake();

        // T4: stall mid-sweep (with start ignored), then backpressure.
        // p=80; r=00 on units 0,3,6,9,12,15 else C0 -> 0x9249, 6 ones.
        start_sweep();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                bus.prob_data = 8'hFF;
                bus.rand_data = 8'h00;
                for (int s = 0; s < 3; s++) begin
                    bus.start = (s == 1);
                    tick();
                end
                bus.start = 1'b0;
                chk("t4_stall_fsm",  32'(state_dbg),       32'd1);
                chk("t4_stall_data", 32'(bus.state_data),  32'h0049);
                chk("t4_stall_cnt",  32'(bus.ones_count),  32'd3);
            end
            accept(8'h80, (i % 3 == 0) ? 8'h00 : 8'hC0);
        end
        for (int s = 0; s < 4; s++) begin
            bus.start = (s == 2);
            chk("t4_bp_valid", 32'(bus.state_valid), 32'd1);
            chk("t4_bp_data",  32'(bus.state_data),  32'h9249);
            chk("t4_bp_count", 32'(bus.ones_count),  32'd6);
            tick();
        end
        bus.start = 1'b0;
        chk("t4_bp_final", 32'(bus.state_data), 32'h9249);

        // T5: back-to-back start on the handshake edge.
        bus.start       = 1'b1;
        bus.state_ready = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.state_ready = 1'b0;
        chk("t5_valid", 32'(bus.state_valid), 32'd0);
        chk("t5_fsm",   32'(state_dbg),       32'd1);
        chk("t5_clear", 32'(bus.state_data),  32'd0);
        chk("t5_cnt0",  32'(bus.ones_count),  32'd0);
        for (int i = 0; i < 16; i++) accept((i < 4) ? 8'hFF : 8'h00, 8'h00);
        chk("t5_data",  32'(bus.state_data), 32'h000F);
        chk("t5_count", 32'(bus.ones_count), 32'd4);
        handshake();
        chk("t5_idle", 32'(state_dbg), 32'd0);

        // T6: LFSR-driven random words (x^8+x^6+x^5+x^4+1, seed 5A), p=40.
        // Mean ones per sweep about 16*63/255 ~ 3.95; require 3..5 over 64 sweeps.
        lfsr  = 8'h5A;
        total = 0;
        for (int s = 0; s < 64; s++) begin
            bus.start     = 1'b1;
            bus.rand_data = lfsr;
            tick();
            lfsr = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
            bus.start = 1'b0;
            for (int i = 0; i < 16; i++) begin
                bus.prob_valid = 1'b1;
                bus.prob_data  = 8'h40;
                bus.rand_data  = lfsr;
                tick();
                lfsr = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
            end
            bus.prob_valid = 1'b0;
            total += int'(bus.ones_count);
            bus.state_ready = 1'b1;
            bus.rand_data   = lfsr;
            tick();
            lfsr = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
            bus.state_ready = 1'b0;
        end
        chk("t6_mean_in_range", 32'((total >= 192) && (total <= 320)), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
